// File: rtl/divider_32_if.sv
// Operand/result handshake bundle shared by the arithmetic-unit blocks.
// The master drives operands and takes results; the slave is the arithmetic block.
interface divider_32_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             input_stb;
  logic             input_ack;
  logic [WIDTH-1:0] output_z;
  logic [WIDTH-1:0] output_r;
  logic             output_dbz;
  logic             output_z_stb;
  logic             output_z_ack;

  modport master (
    output input_a, input_b, input_stb, output_z_ack,
    input  input_ack, output_z, output_r, output_dbz, output_z_stb
  );

  modport slave (
    input  input_a, input_b, input_stb, output_z_ack,
    output input_ack, output_z, output_r, output_dbz, output_z_stb
  );
endinterface

// File: rtl/divider_32.sv
// Sequential unsigned restoring divider: one quotient bit per clock, quotient
// and remainder returned over a strobe/acknowledge handshake.
module divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  divider_32_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_z;
  logic [WIDTH-1:0]   r_r;
  logic               r_dbz;

  logic signed [WIDTH:0] w_trial;
  logic                  w_neg;
  logic [WIDTH-1:0]      w_quot_nxt;
  logic [WIDTH-1:0]      w_rem_nxt;
  logic                  w_last;

  // Partial remainder stays below the divisor, so the top bit of the
  // WIDTH+1-bit difference is exactly the borrow, even with divisor MSB set.
  assign w_trial    = $signed({r_rem, r_quot[WIDTH-1]} - {1'b0, r_div});
  assign w_neg      = w_trial[WIDTH];
  assign w_quot_nxt = {r_quot[WIDTH-2:0], ~w_neg};
  assign w_rem_nxt  = w_neg ? {r_rem[WIDTH-2:0], r_quot[WIDTH-1]}
                            : w_trial[WIDTH-1:0];
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.input_stb) begin
            r_div  <= bus.input_b;
            r_quot <= bus.input_a;
            r_rem  <= '0;
            r_cnt  <= '0;
            if (bus.input_b != '0) begin
              r_state <= ST_DIVIDE;
            end else begin
              r_z     <= '1;
              r_r     <= bus.input_a;
              r_dbz   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DIVIDE: begin
          r_quot <= w_quot_nxt;
          r_rem  <= w_rem_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_z     <= w_quot_nxt;
            r_r     <= w_rem_nxt;
            r_dbz   <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.output_z_ack) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.input_ack    = (r_state == ST_IDLE);
  assign bus.output_z_stb = (r_state == ST_DONE);
  assign bus.output_z     = r_z;
  assign bus.output_r     = r_r;
  assign bus.output_dbz   = r_dbz;

endmodule

// File: doc/divider_32.md
# divider_32

Sequential unsigned integer divider: the inverse companion to the team's 32-bit multiplier. It accepts a dividend/divisor pair over a strobe/acknowledge handshake and computes quotient and remainder by restoring division, one quotient bit per clock. It returns the result over a second strobe/acknowledge handshake. It sits beside the multiplier in the arithmetic unit and uses the same operand/result port style, so one bench drives both.

## Interface
- WIDTH, 32: operand, quotient and remainder width. WIDTH is at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it low clears the state immediately. Release is synchronous to clk.
- input_a  in  WIDTH  dividend; sampled on the accepting edge.
- input_b  in  WIDTH  divisor; sampled on the same edge.
- input_stb  in  1  operands valid.
- input_ack  out  1  block ready to accept operands; equals (state == IDLE).
- output_z  out  WIDTH  quotient.
- output_r  out  WIDTH  remainder.
- output_dbz  out  1  divide-by-zero flag for the current result.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  consumer has taken the result.

## Operation
- States: IDLE, DIVIDE, DONE. Reset enters IDLE.
- IDLE:
  - input_ack = 1.
  - On an edge with input_stb = 1, the operands are captured:
    - divisor register = input_b
    - quotient shift register = input_a
    - partial remainder = 0
    - iteration counter = 0
  - Next state is DIVIDE if input_b != 0, else DONE with the divide-by-zero path.
- DIVIDE, one iteration per cycle:
  - Form the WIDTH+1-bit trial value t = {partial remainder, MSB of quotient register} - {0, divisor}.
  - Shift the quotient register left by 1.
  - If t is non-negative: partial remainder = t[WIDTH-1:0] and quotient LSB = 1.
  - Otherwise: partial remainder = {partial remainder[WIDTH-2:0], old quotient MSB} and quotient LSB = 0.
  - The counter increments each iteration. After iteration WIDTH-1 (counter == WIDTH-1), go to DONE.
  - The subtract is WIDTH+1 bits wide so the carry-out is never lost, including when the divisor's MSB is set.
- DONE:
  - output_z_stb = 1. output_z, output_r and output_dbz are held stable.
  - On an edge with output_z_ack = 1, return to IDLE.
  - output_z_stb stays high indefinitely while output_z_ack = 0 (back-pressure).
- Divide-by-zero path:
  - output_z = all ones, output_r = input_a, output_dbz = 1.
  - No iterations are performed.
- output_dbz is 0 for every result with a nonzero divisor.
- input_stb is ignored outside IDLE. Operands that change while DIVIDE or DONE is active have no effect.
- output_z_ack is ignored outside DONE.
- Result registers keep their last values in IDLE. Only output_z_stb qualifies them.

## Timing
- Reset values (rst = 0): state IDLE, input_ack = 1, output_z_stb = 0, output_z = 0, output_r = 0, output_dbz = 0, counter = 0.
- An input transfer is an edge E0 where input_stb && input_ack.
- Normal latency:
  - DIVIDE occupies edges E1..EWIDTH.
  - output_z_stb rises after edge EWIDTH, so it is high in the cycle following the WIDTH-th iteration (33 cycles after E0 for WIDTH = 32).
- Divide-by-zero latency: output_z_stb is high immediately after E0, i.e. 1 cycle.
- Output handshake:
  - The result transfers on the first edge with output_z_stb && output_z_ack.
  - output_z_stb and input_ack change after that same edge: output_z_stb goes to 0 and input_ack goes to 1.
- Minimum spacing between accepted operands is WIDTH+2 cycles. A new operand cannot be accepted on the edge that completes the output handshake.
- Reset mid-operation (any state): return to the reset values asynchronously. The partial result is discarded and no stale output_z_stb appears after release.

## Test plan
- 100 / 7 with output_z_ack tied high:
  - output_z = 14, output_r = 2, output_dbz = 0.
  - output_z_stb is high exactly 33 cycles after the accepting edge, for 1 cycle.
  - input_ack returns to 1 the following cycle.
- 0xFFFFFFFF / 1 and 0xFFFFFFFF / 0x80000000:
  - First case: z = 0xFFFFFFFF, r = 0.
  - Second case: z = 1, r = 0x7FFFFFFF. This checks the WIDTH+1-bit carry.
- 5 / 9 and 0 / 3:
  - First case: z = 0, r = 5.
  - Second case: z = 0, r = 0.
  - Both take full 33-cycle latency.
- 0x1234 / 0:
  - output_dbz = 1, z = 0xFFFFFFFF, r = 0x1234.
  - output_z_stb is high 1 cycle after accept.
  - A following 100 / 7 gives output_dbz = 0.
- Back-pressure on 1000 / 10 with output_z_ack held low for 10 cycles:
  - z = 100 and r = 0 stay stable with output_z_stb = 1.
  - input_ack stays 0, and a pulse on input_stb during this window is ignored.
  - The result transfers on the first output_z_ack edge.
- Reset mid-divide: pull rst low at iteration 10 of 100 / 7.
  - All outputs take their reset values at once and input_ack = 1.
  - After release, 100 / 7 yields z = 14, r = 2 with normal latency.
